// File: rtl/mmio_read_mux.sv
// MEM-stage read-data selector: DMEM pass-through, or a stalled req/ack read
// from one of NCH memory-mapped peripherals with a timeout abort.
//
// state  | meaning
// S_IDLE | no transaction; DMEM data passes through, a mapped load starts one
// S_WAIT | request held on channel r_ch, pipeline stalled, timeout counting
// S_DONE | registered peripheral (or timeout) word presented, pipeline released
module mmio_read_mux #(
  parameter int                NCH     = 7,
  parameter logic [12*NCH-1:0] CH_ADDR = {12'h834, 12'h828, 12'h824, 12'h820,
                                          12'h814, 12'h80c, 12'h808},
  parameter int                TIMEOUT = 16,
  parameter logic [31:0]       TO_DATA = 32'hDEAD_BEEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_en,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_dmem_rdata,
  input  logic [32*NCH-1:0] i_per_rdata,
  input  logic [NCH-1:0]    i_per_ack,
  output logic [NCH-1:0]    o_per_req,
  output logic [31:0]       o_rdata,
  output logic              o_stall,
  output logic              o_timeout_err
);

  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CHW-1:0]  r_ch, w_hit_ch;
  logic [CNTW-1:0] r_cnt;
  logic [31:0]     r_data;
  logic [NCH-1:0]  r_per_req;
  logic            r_timeout_err;
  logic            w_hit, w_ack, w_timeout;
  logic [31:0]     w_ch_rdata;
  logic            w_unused;

  // Only the 12-bit page offset takes part in the decode.
  assign w_unused = ^i_addr[31:12];

  // Descending scan so the lowest matching channel is the one left standing.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_load_en && i_addr[11] && (i_addr[11:0] == CH_ADDR[12*i +: 12])) begin
        w_hit    = 1'b1;
        w_hit_ch = CHW'(i);
      end
    end
  end

  assign w_ack      = i_per_ack[r_ch];
  assign w_ch_rdata = i_per_rdata[32*r_ch +: 32];
  assign w_timeout  = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hit) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!i_load_en)              w_state_nxt = S_IDLE;
        else if (w_ack || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_ch          <= '0;
      r_cnt         <= '0;
      r_data        <= '0;
      r_per_req     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_ch      <= w_hit_ch;
            r_cnt     <= '0;
            r_per_req <= NCH'(1) << w_hit_ch;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A flush beats everything; an ack beats a coincident timeout.
          if (!i_load_en) begin
            r_per_req <= '0;
          end else if (w_ack) begin
            r_data    <= w_ch_rdata;
            r_per_req <= '0;
          end else if (w_timeout) begin
            r_data        <= TO_DATA;
            r_timeout_err <= 1'b1;
            r_per_req     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_per_req     = r_per_req;
  assign o_timeout_err = r_timeout_err;
  assign o_rdata       = (r_state == S_DONE) ? r_data : i_dmem_rdata;
  // Gated by reset so a held mapped load cannot stall while in reset.
  assign o_stall       = i_rst_n & (((r_state == S_IDLE) & w_hit) | (r_state == S_WAIT));

endmodule
